fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, byte address width of fetch PCs.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous active-low reset; all state is clocked on the rising edge of clk_i.
REQ-006 clk_i  input  1  clock.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 redirect_i  input  1  taken branch/jump from execute (PCSrcE); flush and restart.
REQ-009 redirect_pc_i  input  PC_WIDTH  restart address, valid with redirect_i.
REQ-010 imem_req_o  output  1  fetch request to instruction memory, one-cycle pulse.
REQ-011 imem_addr_o  output  PC_WIDTH  fetch address, valid with imem_req_o.
REQ-012 imem_valid_i  input  1  response strobe, 1 or more cycles after request.
REQ-013 imem_rdata_i  input  INSTRUCTION_WIDTH  response instruction, valid with imem_valid_i.
REQ-014 valid_o  output  1  queue head holds a valid instruction.
REQ-015 ready_i  input  1  decode register accepting (not StallD).
REQ-016 instr_o  output  INSTRUCTION_WIDTH  head instruction.
REQ-017 pc_o  output  PC_WIDTH  head PC.
REQ-018 pc_plus4_o  output  PC_WIDTH  pc_o + 4, modulo 2^PC_WIDTH.

Function
REQ-019 State: fetch_pc, req_pc, pending flag, drop flag, DEPTH-entry {instr, pc} FIFO with read/write pointers and count (0..DEPTH).
REQ-020 imem_req_o SHALL be 1 iff pending=0, count<DEPTH, redirect_i=0; imem_addr_o SHALL equal fetch_pc at all times.
REQ-021 On request: pending<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps modulo 2^PC_WIDTH).
REQ-022 At most one request outstanding; no new request in the cycle a response arrives (pending still 1).
REQ-023 imem_valid_i with pending=1, drop=0, redirect_i=0: push {imem_rdata_i, req_pc}, pending<=0.
REQ-024 imem_valid_i with pending=1, drop=1: discard data, pending<=0, drop<=0.
REQ-025 imem_valid_i with pending=0: ignored, no state change.
REQ-026 Pop when valid_o=1 and ready_i=1; pointers wrap modulo DEPTH.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance; legal in any count including DEPTH-1 and full-with-pop.
REQ-028 valid_o = (count != 0); no combinational bypass: pushed entry visible on outputs the cycle after the response.
REQ-029 Output latency: request cycle N, response cycle N+k, valid_o high at N+k+1.
REQ-030 Head outputs SHALL hold stable while valid_o=1 and ready_i=0.
REQ-031 redirect_i=1 has priority over push and pop: count<=0, pointers<=0, fetch_pc<=redirect_pc_i, no request that cycle.
REQ-032 Redirect with pending=1 and no response that cycle: drop<=1, pending stays 1.
REQ-033 Redirect with response in the same cycle: data discarded, pending<=0, drop<=0.
REQ-034 First request after redirect SHALL be to redirect_pc_i, issued the cycle after redirect at earliest (after the dropped response, if any).
REQ-035 Back-to-back redirects: last one wins; drop stays set until the single outstanding response returns.

Reset
REQ-036 While rst_ni=0: fetch_pc=RESET_PC, count=0, pointers=0, pending=0, drop=0; valid_o=0, imem_req_o=0.
REQ-037 Reset mid-operation discards all queued entries and any outstanding request; a response arriving later with pending=0 is ignored per REQ-025.
REQ-038 First cycle after rst_ni rises: imem_req_o=1, imem_addr_o=RESET_PC.

Verification
REQ-039 Single-cycle memory, ready_i=1: after reset pc_o sequence 0x0,0x4,0x8 with instr_o matching memory words; pc_plus4_o = pc_o+4.
REQ-040 ready_i=0 held: exactly 4 entries (PCs 0x0..0xC) fill, then imem_req_o stays 0; raise ready_i -> request to 0x10 resumes, outputs 0x0 first.
REQ-041 3-cycle memory latency, request to 0x8 outstanding, redirect_i=1 with redirect_pc_i=0x100: queue empties, late 0x8 response dropped, next request addr 0x100, next pc_o=0x100.
REQ-042 Redirect coincident with response: response discarded, request to redirect_pc_i issued next cycle.
REQ-043 fetch_pc at 0xFFFF_FFFC: next request address 0x0000_0000; pc_plus4_o for head 0xFFFF_FFFC is 0x0.
REQ-044 rst_ni pulsed low with 3 queued entries and pending request: valid_o=0 immediately, stale response ignored, first post-reset request addr RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with one outstanding memory request
// and a DEPTH-entry {instr, pc} queue feeding decode; redirect flushes and restarts.
`default_nettype none

module fetch_queue #(
  parameter int                  PC_WIDTH          = 32,
  parameter int                  INSTRUCTION_WIDTH = 32,
  parameter int                  DEPTH             = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         redirect_i,
  input  logic [PC_WIDTH-1:0]          redirect_pc_i,
  output logic                         imem_req_o,
  output logic [PC_WIDTH-1:0]          imem_addr_o,
  input  logic                         imem_valid_i,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [INSTRUCTION_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [PC_WIDTH-1:0]          pc_plus4_o
);

  localparam int                  PTR_W   = $clog2(DEPTH);
  localparam int                  CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL    = CNT_W'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0]          fetch_pc;
  logic [PC_WIDTH-1:0]          req_pc;
  logic                         pending;
  logic                         drop;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];

  logic issue;
  logic accept;
  logic push;
  logic pop;

  // Gating with rst_ni keeps the request low for the whole reset assertion.
  assign issue  = rst_ni && !pending && (count != FULL) && !redirect_i;
  assign accept = imem_valid_i && pending;
  assign push   = accept && !drop && !redirect_i;
  assign pop    = valid_o && ready_i && !redirect_i;

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc;
  assign valid_o     = (count != '0);
  assign instr_o     = instr_mem[rd_ptr];
  assign pc_o        = pc_mem[rd_ptr];
  assign pc_plus4_o  = pc_o + PC_STEP;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      pending  <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // An in-flight request cannot be cancelled; remember to discard its data.
      if (accept) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end else if (pending) begin
        drop    <= 1'b1;
      end
    end else begin
      if (issue) begin
        pending  <= 1'b1;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end else if (accept) begin
        pending  <= 1'b0;
        drop     <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]    <= req_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with a
// variable-latency instruction memory responder driven from the stimulus tasks.
`default_nettype none

module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int          errors = 0;
  int          checks = 0;
  int          lat = 1;
  int          resp_cd = 0;
  logic [31:0] resp_addr = '0;

  fetch_queue #(
    .PC_WIDTH(32), .INSTRUCTION_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_valid_i(imem_valid_i),
    .imem_rdata_i(imem_rdata_i), .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle; the memory model answers a request 'lat' cycles later.
  task automatic tick();
    logic        was_req;
    logic [31:0] was_addr;
    #1;
    was_req  = imem_req_o;
    was_addr = imem_addr_o;
    @(posedge clk_i);
    #1;
    imem_valid_i = 1'b0;
    if (was_req) begin
      resp_cd   = lat;
      resp_addr = was_addr;
    end
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        imem_valid_i = 1'b1;
        imem_rdata_i = memword(resp_addr);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    redirect_i   = 1'b0;
    imem_valid_i = 1'b0;
    resp_cd      = 0;
    #1;
    chk_b("rst_valid", valid_o, 1'b0);
    chk_b("rst_req", imem_req_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_o && n < 30) begin
      tick();
      n++;
    end
    chk_b({tag, "_valid_timeout"}, valid_o, 1'b1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!imem_req_o && n < 30) begin
      tick();
      n++;
    end
    chk_b({tag, "_req_timeout"}, imem_req_o, 1'b1);
    chk_w({tag, "_addr"}, imem_addr_o, addr);
  endtask

  initial begin
    // Single-cycle memory, decode always ready.
    lat = 1; ready_i = 1'b1;
    do_reset();
    chk_b("first_req", imem_req_o, 1'b1);
    chk_w("first_addr", imem_addr_o, 32'h0);
    tick();
    chk_b("no_bypass", valid_o, 1'b0);
    chk_b("no_req_on_resp", imem_req_o, 1'b0);
    tick();
    chk_b("head0_valid", valid_o, 1'b1);
    chk_w("head0_pc", pc_o, 32'h0);
    chk_w("head0_instr", instr_o, memword(32'h0));
    chk_w("head0_pc4", pc_plus4_o, 32'h4);
    for (int i = 1; i < 3; i++) begin
      tick();
      wait_valid("seq");
      chk_w("seq_pc", pc_o, 32'(i * 4));
      chk_w("seq_instr", instr_o, memword(32'(i * 4)));
      chk_w("seq_pc4", pc_plus4_o, 32'(i * 4 + 4));
    end

    // Decode stalled: queue fills to four entries, then requests stop.
    ready_i = 1'b0;
    do_reset();
    repeat (12) tick();
    chk_b("full_no_req", imem_req_o, 1'b0);
    chk_b("full_valid", valid_o, 1'b1);
    chk_w("full_head_pc", pc_o, 32'h0);
    chk_w("full_head_instr", instr_o, memword(32'h0));
    repeat (4) tick();
    chk_b("full_still_no_req", imem_req_o, 1'b0);
    chk_w("stall_hold_pc", pc_o, 32'h0);
    ready_i = 1'b1;
    tick();
    chk_b("resume_req", imem_req_o, 1'b1);
    chk_w("resume_addr", imem_addr_o, 32'h10);
    chk_w("drain_pc1", pc_o, 32'h4);
    tick();
    chk_w("drain_pc2", pc_o, 32'h8);
    tick();
    chk_w("drain_pc3", pc_o, 32'hC);
    chk_b("drain_valid3", valid_o, 1'b1);

    // Three-cycle memory, redirect while the 0x8 request is outstanding.
    lat = 3; ready_i = 1'b0;
    do_reset();
    tick();
    wait_req("lat3_a", 32'h4);
    tick();
    wait_req("lat3_b", 32'h8);
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    chk_b("redir_no_req", imem_req_o, 1'b0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk_b("redir_flushed", valid_o, 1'b0);
    chk_b("redir_wait_drop", imem_req_o, 1'b0);
    tick();
    chk_b("drop_cycle_no_req", imem_req_o, 1'b0);
    tick();
    chk_b("after_drop_req", imem_req_o, 1'b1);
    chk_w("after_drop_addr", imem_addr_o, 32'h100);
    chk_b("drop_not_pushed", valid_o, 1'b0);
    wait_valid("redir");
    chk_w("redir_pc", pc_o, 32'h100);
    chk_w("redir_instr", instr_o, memword(32'h100));

    // Redirect in the same cycle as the response.
    lat = 2; ready_i = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    #1;
    chk_b("coinc_req", imem_req_o, 1'b1);
    chk_w("coinc_addr", imem_addr_o, 32'h200);
    chk_b("coinc_discard", valid_o, 1'b0);
    wait_valid("coinc");
    chk_w("coinc_pc", pc_o, 32'h200);
    chk_w("coinc_pc4", pc_plus4_o, 32'h204);

    // Address wrap at the top of the PC space.
    lat = 1; ready_i = 1'b0;
    do_reset();
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    #1;
    chk_b("wrap_req0", imem_req_o, 1'b1);
    chk_w("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    tick();
    chk_b("wrap_valid", valid_o, 1'b1);
    chk_w("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk_w("wrap_pc4", pc_plus4_o, 32'h0);
    chk_b("wrap_req1", imem_req_o, 1'b1);
    chk_w("wrap_addr1", imem_addr_o, 32'h0);

    // Reset with three queued entries and a request in flight.
    lat = 3; ready_i = 1'b0;
    do_reset();
    tick();
    wait_req("mid_a", 32'h4);
    tick();
    wait_req("mid_b", 32'h8);
    tick();
    wait_req("mid_c", 32'hC);
    chk_b("mid_valid", valid_o, 1'b1);
    chk_w("mid_head", pc_o, 32'h0);
    tick();
    rst_ni = 1'b0;
    #1;
    chk_b("mid_rst_valid", valid_o, 1'b0);
    chk_b("mid_rst_req", imem_req_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
    chk_b("post_rst_req", imem_req_o, 1'b1);
    chk_w("post_rst_addr", imem_addr_o, 32'h0);
    tick();
    chk_b("stale_ignored", valid_o, 1'b0);
    chk_b("post_rst_pending", imem_req_o, 1'b0);
    wait_valid("post_rst");
    chk_w("post_rst_pc", pc_o, 32'h0);
    chk_w("post_rst_instr", instr_o, memword(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
